// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780 character LCD controller, 4-bit bus, write-only.
//
// After reset the block waits T_PWRUP cycles, sends the four-nibble 4-bit-mode
// wake-up sequence, configures the panel (2 lines, entry increment, display
// on, clear) and parks in READY. A start request copies the 32-character
// frame into a local buffer and writes it to both lines. Requests that arrive
// while the controller is busy are merged into one pending refresh.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-high reset
//   start    : one-cycle frame refresh request
//   strdata  : 32 ASCII chars, [255:248] = line 1 col 0 ... [7:0] = line 2 col 15
//   busy     : high whenever the controller is not in READY
//   done     : one-cycle pulse at the end of every frame
//   lcd_e    : panel enable strobe
//   lcd_rs   : panel register select (0 = command, 1 = data)
//   lcd_rw   : panel read/write, tied to write
//   lcd_dat  : panel 4-bit data bus
module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_E     = 12,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_INIT  = 205000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] strdata,
    output logic         busy,
    output logic         done,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [3:0]   lcd_dat
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves every wait, so it is sized for the longest one.
    localparam int T_MAX = imax(imax(imax(T_PWRUP, T_E), imax(T_NIB, T_CMD)),
                                imax(T_CLR, T_INIT));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(T_E - 1);
    localparam logic [CNT_W-1:0] NIB_LAST   = CNT_W'(T_NIB - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(T_INIT - 1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CONFIG,
        ST_READY,
        ST_FRAME
    } state_t;

    // Nibble/wait sub-sequencer shared by INIT, CONFIG and FRAME.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_GAP,
        PH_WAIT
    } phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [5:0]       idx, idx_n;      // item number within the current sequence
    logic             lo, lo_n;        // sending the low nibble of a byte
    logic             pending, pending_n;
    logic             load;
    logic [255:0]     frame_buf;

    logic [7:0]       cur_byte;
    logic             cur_rs;
    logic [4:0]       char_k;
    logic [CNT_W-1:0] wait_last;
    logic             last_item;
    logic             nib_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_PWRUP;
            phase   <= PH_IDLE;
            cnt     <= '0;
            idx     <= '0;
            lo      <= 1'b0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            lo      <= lo_n;
            pending <= pending_n;
        end
    end

    // Frame buffer is pure data: only written on capture, never reset.
    always_ff @(posedge clk) begin
        if (load) begin
            frame_buf <= strdata;
        end
    end

    // Byte (and register select) for the item currently being sent.
    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        char_k   = '0;
        case (state)
            // Init items are single nibbles carried in the high half.
            ST_INIT:   cur_byte = (idx == 6'd3) ? 8'h20 : 8'h30;
            ST_CONFIG: begin
                case (idx[1:0])
                    2'd0:    cur_byte = 8'h28;
                    2'd1:    cur_byte = 8'h06;
                    2'd2:    cur_byte = 8'h0C;
                    default: cur_byte = 8'h01;
                endcase
            end
            ST_FRAME: begin
                if (idx == 6'd0) begin
                    cur_byte = 8'h80;
                end else if (idx == 6'd17) begin
                    cur_byte = 8'hC0;
                end else begin
                    cur_rs = 1'b1;
                    char_k = (idx < 6'd17) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
                    // Character k sits at bits [255-8k -: 8] = [(31-k)*8 +: 8].
                    cur_byte = frame_buf[{~char_k, 3'b000} +: 8];
                end
            end
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        if (state == ST_INIT) begin
            wait_last = INIT_LAST;
        end else if (!cur_rs && cur_byte == 8'h01) begin
            wait_last = CLR_LAST;
        end else begin
            wait_last = CMD_LAST;
        end
        last_item = (state == ST_FRAME) ? (idx == 6'd33) : (idx == 6'd3);
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        idx_n     = idx;
        lo_n      = lo;
        // Requests while busy collapse into one pending refresh.
        pending_n = pending | (start && state != ST_READY);
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    state_n = ST_INIT;
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                    idx_n   = '0;
                    lo_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (start || pending) begin
                    load      = 1'b1;
                    pending_n = 1'b0;
                    state_n   = ST_FRAME;
                    phase_n   = PH_SETUP;
                    cnt_n     = '0;
                    idx_n     = '0;
                    lo_n      = 1'b0;
                end
            end
            default: begin
                case (phase)
                    PH_SETUP: begin
                        phase_n = PH_PULSE;
                        cnt_n   = '0;
                    end
                    PH_PULSE: begin
                        if (cnt == E_LAST) begin
                            phase_n = PH_HOLD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    PH_HOLD: begin
                        cnt_n   = '0;
                        phase_n = (state == ST_INIT || lo) ? PH_WAIT : PH_GAP;
                    end
                    PH_GAP: begin
                        if (cnt == NIB_LAST) begin
                            phase_n = PH_SETUP;
                            lo_n    = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    PH_WAIT: begin
                        if (cnt == wait_last) begin
                            cnt_n = '0;
                            lo_n  = 1'b0;
                            if (!last_item) begin
                                idx_n   = idx + 1'b1;
                                phase_n = PH_SETUP;
                            end else if (state == ST_INIT) begin
                                state_n = ST_CONFIG;
                                idx_n   = '0;
                                phase_n = PH_SETUP;
                            end else begin
                                // End of CONFIG or FRAME; only a frame reports done.
                                done    = (state == ST_FRAME);
                                state_n = ST_READY;
                                phase_n = PH_IDLE;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: begin
                        phase_n = PH_SETUP;
                        cnt_n   = '0;
                    end
                endcase
            end
        endcase
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign nib_phase = (phase == PH_SETUP) || (phase == PH_PULSE) || (phase == PH_HOLD);
    assign lcd_e     = (phase == PH_PULSE);
    assign lcd_dat   = nib_phase ? (lo ? cur_byte[3:0] : cur_byte[7:4]) : 4'h0;
    assign lcd_rs    = nib_phase ? cur_rs : 1'b0;
    assign lcd_rw    = 1'b0;
    assign busy      = (state != ST_READY);

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRUP, 750000, power-up wait in clk cycles before the first init nibble.
REQ-002 Parameter T_E, 12, lcd_e high width in cycles.
REQ-003 Parameter T_NIB, 50, gap in cycles between the high and low nibble of a byte.
REQ-004 Parameter T_CMD, 2000, wait in cycles after the low nibble of every byte except clear.
REQ-005 Parameter T_CLR, 82000, wait in cycles after the low nibble of the clear (0x01) command.
REQ-006 Parameter T_INIT, 205000, wait in cycles after each of the 4 init nibbles.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  one-cycle frame refresh request.
REQ-010 strdata  input  256  32 ASCII chars; [255:248] = line 1 col 0 ... [135:128] = line 1 col 15, [127:120] = line 2 col 0 ... [7:0] = line 2 col 15.
REQ-011 busy  output  1  high while not in READY.
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 lcd_e, lcd_rs, lcd_rw  output  1 each  HD44780 strobe, register select, read/write.
REQ-014 lcd_dat  output  4  HD44780 4-bit data bus.

Function
REQ-015 States SHALL be PWRUP, INIT, CONFIG, READY, FRAME, with a nibble/wait sub-sequencer shared by INIT, CONFIG and FRAME.
REQ-016 PWRUP SHALL count T_PWRUP cycles, then enter INIT.
REQ-017 INIT SHALL send single nibbles 0x3, 0x3, 0x3, 0x2 with rs=0, each followed by T_INIT cycles, then enter CONFIG.
REQ-018 CONFIG SHALL send bytes 0x28, 0x06, 0x0C, 0x01 with rs=0, then enter READY with done=0.
REQ-019 Each nibble SHALL last 1 setup cycle (lcd_dat/lcd_rs valid, lcd_e=0), T_E cycles with lcd_e=1, then 1 hold cycle (lcd_e=0, lcd_dat/lcd_rs unchanged).
REQ-020 Each byte SHALL consist of the high nibble, T_NIB idle cycles, the low nibble, then T_CMD idle cycles, or T_CLR for 0x01.
REQ-021 lcd_rw SHALL be 0 at all times.
REQ-022 In READY, start=1 SHALL capture strdata into an internal frame buffer and enter FRAME on the next cycle.
REQ-023 FRAME SHALL send byte 0x80 (rs=0), chars 0-15 (rs=1), byte 0xC0 (rs=0), then chars 16-31 (rs=1): 34 bytes, 68 lcd_e pulses.
REQ-024 After the final T_CMD wait of FRAME, done SHALL pulse for 1 cycle and the state SHALL return to READY.
REQ-025 start asserted in any state other than READY SHALL set a single-entry pending flag; repeated requests SHALL merge into that one flag.
REQ-026 With pending set on entry to READY, the block SHALL capture strdata and enter FRAME on the next cycle, as if start had arrived, and clear pending.
REQ-027 strdata changes during FRAME SHALL NOT affect the frame in progress.
REQ-028 If start arrives in the same cycle as the done pulse, it SHALL set pending and produce exactly one further frame.
REQ-029 All wait counters SHALL be wide enough for the largest parameter; no counter SHALL wrap within a wait.

Reset
REQ-030 rst=1 SHALL asynchronously force: state PWRUP, counters 0, pending 0, busy 1, done 0, lcd_e 0, lcd_rs 0, lcd_rw 0, lcd_dat 0.
REQ-031 rst asserted mid-nibble, including while lcd_e=1, SHALL drop lcd_e immediately and restart from PWRUP after release, with no frame resumption.

Verification (bench parameters T_PWRUP=10, T_E=2, T_NIB=1, T_CMD=4, T_CLR=8, T_INIT=6)
REQ-032 Release reset, no start -> exactly 12 lcd_e pulses (each 2 cycles high) before READY; nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1, all with rs=0; first pulse no earlier than cycle 10.
REQ-033 In READY, strdata="ABCD..." with start pulse -> 68 pulses: 0x80, 16 chars rs=1, 0xC0, 16 chars rs=1, in MSB-first order; one done pulse; busy falls the cycle after done.
REQ-034 Toggle strdata every cycle during FRAME -> transmitted chars equal the value captured at start.
REQ-035 Three start pulses during a frame -> exactly one additional frame, then READY.
REQ-036 Assert rst while lcd_e=1 in FRAME -> lcd_e=0 in the same cycle; after release the full REQ-032 init sequence repeats and done stays 0.
REQ-037 Check every nibble: lcd_dat and lcd_rs stable from the setup cycle through the hold cycle; lcd_rw=0 throughout all tests.
